if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//   Instruction-fetch initiator that drives the PC into a synchronous-read instruction memory.
//   The memory returns a word one clock after its address is sampled, and it reads every cycle with no enable.
//   The block tracks the in-flight request, absorbs the 1-cycle latency and buffers a response across downstream stalls.
//   It presents {pc, instr} to the decode stage as a valid/stall stream and handles branch/jump redirects.
// PARAMETERS
//   RESET_PC   32'h0000_0000   first fetch address after reset (bits [1:0] must be 0)
//   CNT_W      32              width of the perf counters (used only with IF_PERF_CNT_EN)
// PORTS
//   clk             in   1    single clock; every register updates on posedge
//   rst             in   1    synchronous, active-high reset
//   imem_addr       out  32   word address to the instruction memory; bits [1:0] are always 2'b00
//   imem_instr      in   32   memory read data for the imem_addr sampled at the previous posedge
//   redirect_valid  in   1    taken branch/jump: restart fetch at redirect_pc
//   redirect_pc     in   32   redirect target; bits [1:0] are ignored and forced to 0
//   stall           in   1    decode is not ready; the output must be held
//   if_valid        out  1    if_pc/if_instr hold a valid fetched instruction
//   if_pc           out  32   PC of the presented instruction (0 when if_valid=0)
//   if_instr        out  32   presented instruction (0 when if_valid=0)
// BEHAVIOUR
//   State: pc_q (next address to issue); infl_v/infl_pc (address issued last cycle, data on imem_instr now);
//   hold_v/hold_pc/hold_instr (1-entry skid buffer).
//   Output mux:
//     - hold_v=1: present the hold registers.
//     - Else infl_v=1: present {infl_pc, imem_instr}.
//     - Else: if_valid=0.
//     - redirect_valid=1 forces if_valid=0 in that same cycle.
//   Transfer: an instruction is consumed when if_valid && !stall.
//   Issue rule: issue = redirect_valid | !stall | (!hold_v & !infl_v).
//     - On issue: infl_v<=1, infl_pc<=imem_addr, pc_q<=imem_addr+4.
//     - Otherwise: infl_v<=0, pc_q held.
//   Address: imem_addr = redirect_valid ? {redirect_pc[31:2],2'b00} : pc_q, combinational.
//     - When not issuing, imem_addr stays at pc_q (stable).
//   Capture: stall & infl_v & !hold_v & !redirect_valid -> hold <= {infl_pc, imem_instr}, hold_v<=1.
//   Hold release: hold_v & !stall -> hold_v<=0. Issue is allowed in that same cycle (no bubble).
//   Invariant: hold_v & infl_v never both 1 while stall=1. Instructions are never dropped or duplicated.
//   Throughput: with stall=0, one instruction per cycle. Fetch latency = 1 cycle from issue to if_valid.
//   Redirect (highest priority below rst):
//     - Flushes hold_v and the old in-flight request.
//     - Issues the target immediately, even under stall.
//     - The target appears with if_valid the next cycle.
//   Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0.
//   Reset: sync, overrides everything.
//     - pc_q<=RESET_PC, infl_v<=0, hold_v<=0, hold_pc/hold_instr<=0.
//     - While rst=1: if_valid=0, if_pc=0, if_instr=0, imem_addr=RESET_PC.
//     - First cycle after release issues RESET_PC; if_valid rises 1 cycle later.
//     - Reset mid-stall or mid-redirect discards all state; the memory data returned after reset is ignored.
// CONFIGURATION
//   IF_PERF_CNT_EN defined:
//     - Adds outputs fetch_cnt[CNT_W-1:0] (+1 per transfer) and bubble_cnt[CNT_W-1:0] (+1 per cycle with !if_valid & !stall).
//     - Both counters reset to 0 on rst and wrap at 2^CNT_W.
//   IF_PERF_CNT_EN undefined: these ports and registers do not exist; behaviour is otherwise identical.
// TESTING (memory model: 256-word sync-read, word[i]=32'hA000_0000+i)
//   1. Reset and free-run:
//      - Stimulus: rst=1 for 3 cycles, then stall=0.
//      - Response: imem_addr 0,4,8,... each cycle; if_valid rises 1 cycle after release with pc=0, instr=A0000000.
//      - Then pc+4 every cycle with no gaps.
//   2. Single-cycle stall:
//      - Stimulus: stall=1 in the cycle if_pc=0x8.
//      - Response: {0x8, A0000002} held one extra cycle; then 0xC, 0x10 with no loss or duplicate.
//   3. Long stall:
//      - Stimulus: stall=1 for 5 cycles while if_pc=0x10.
//      - Response: output stable at 0x10; imem_addr stable after 1 cycle; resume 0x14 the cycle stall drops.
//   4. Redirect under stall with hold full:
//      - Stimulus: redirect_valid=1, redirect_pc=0x43.
//      - Response: if_valid=0 that cycle; next cycle if_pc=0x40, instr=A0000010.
//      - Output held while stall stays 1, then 0x44.
//   5. Wrap-around:
//      - Stimulus: redirect to 0xFFFF_FFFC.
//      - Response: if_pc 0xFFFF_FFFC then 0x0000_0000.
//   6. Reset mid-operation:
//      - Stimulus: rst=1 during a stall with hold_v=1.
//      - Response: next cycle if_valid=0, imem_addr=RESET_PC; after release the sequence restarts as in test 1.
//      - With IF_PERF_CNT_EN defined: fetch_cnt=0 and bubble_cnt=0.

Source files
------------

// File: rtl/if_fetch_unit.sv
`default_nettype none
// if_fetch_unit: fetch initiator for a 1-cycle sync-read IMEM with a 1-entry skid buffer and redirect.
// Optional macro IF_PERF_CNT_EN adds the fetch_cnt/bubble_cnt performance counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_instr,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             stall,
  output logic             if_valid,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_instr
`ifdef IF_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  localparam logic [31:0] RESET_ADDR = {RESET_PC[31:2], 2'b00};

  logic [31:0] pc_q;
  logic        infl_v;
  logic [31:0] infl_pc;
  logic        hold_v;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;

  logic [31:0] redirect_addr;
  logic        issue;

  assign redirect_addr = {redirect_pc[31:2], 2'b00};

  // Fetch under stall only when nothing is in flight or buffered, so nothing can be lost.
  assign issue = redirect_valid | !stall | (!hold_v & !infl_v);

  always_comb begin
    imem_addr = pc_q;
    if_valid  = 1'b0;
    if_pc     = 32'h0;
    if_instr  = 32'h0;
    if (rst) begin
      imem_addr = RESET_ADDR;
    end else if (redirect_valid) begin
      imem_addr = redirect_addr;
    end else if (hold_v) begin
      if_valid = 1'b1;
      if_pc    = hold_pc;
      if_instr = hold_instr;
    end else if (infl_v) begin
      if_valid = 1'b1;
      if_pc    = infl_pc;
      if_instr = imem_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_ADDR;
      infl_v     <= 1'b0;
      infl_pc    <= 32'h0;
      hold_v     <= 1'b0;
      hold_pc    <= 32'h0;
      hold_instr <= 32'h0;
    end else begin
      if (issue) begin
        infl_v  <= 1'b1;
        infl_pc <= imem_addr;
        pc_q    <= imem_addr + 32'd4;
      end else begin
        infl_v  <= 1'b0;
      end

      // Memory data is only on the bus for one cycle, so a stalled response must be captured now.
      if (redirect_valid) begin
        hold_v <= 1'b0;
      end else if (stall && infl_v && !hold_v) begin
        hold_v     <= 1'b1;
        hold_pc    <= infl_pc;
        hold_instr <= imem_instr;
      end else if (hold_v && !stall) begin
        hold_v <= 1'b0;
      end
    end
  end

  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (if_valid && !stall) fetch_cnt <= fetch_cnt + 1'b1;
      if (!if_valid && !stall) bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// tb_if_fetch_unit: directed + randomized stimulus checked against a stream-level reference model.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  if_fetch_unit #(.RESET_PC(RESET_PC), .CNT_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .imem_addr(imem_addr),
    .imem_instr(imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .stall(stall),
    .if_valid(if_valid),
    .if_pc(if_pc),
    .if_instr(if_instr)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt(fetch_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  always @(posedge clk) imem_instr <= mem[imem_addr[9:2]];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the presented instruction stream as (avail, pc).
  logic        m_avail = 1'b0;
  logic [31:0] m_pc    = RESET_PC;
  logic        p_rst = 1'b1, p_stall = 1'b0, p_rv = 1'b0, p_valid = 1'b0;
  logic [31:0] p_rpc = 32'h0;
  logic [31:0] m_fetch = 0, m_bubble = 0;
  int          quiet = 0;
  logic [31:0] prev_addr = 32'h0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hA000_0000 + {24'h0, a[9:2]};
  endfunction

  task automatic cycle(input logic r, input logic s, input logic v, input logic [31:0] p);
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    @(posedge clk);
    #1;
    if (p_rst) begin
      m_fetch = 0; m_bubble = 0;
    end else if (!p_stall) begin
      if (p_valid) m_fetch = m_fetch + 1;
      else         m_bubble = m_bubble + 1;
    end
    if (p_rst) begin
      m_avail = 1'b0; m_pc = RESET_PC;
    end else if (p_rv) begin
      m_avail = 1'b1; m_pc = {p_rpc[31:2], 2'b00};
    end else if (!m_avail) begin
      m_avail = 1'b1;
    end else if (!p_stall) begin
      m_pc = m_pc + 32'd4;
    end
    rst = r; stall = s; redirect_valid = v; redirect_pc = p;
    #2;
    e_valid = m_avail & !r & !v;
    e_pc    = e_valid ? m_pc : 32'h0;
    e_instr = e_valid ? word_at(m_pc) : 32'h0;
    check("if_valid", {31'h0, if_valid}, {31'h0, e_valid});
    check("if_pc", if_pc, e_pc);
    check("if_instr", if_instr, e_instr);
    check("addr_align", {30'h0, imem_addr[1:0]}, 32'h0);
    if (r) check("addr_rst", imem_addr, RESET_PC);
    else if (v) check("addr_redirect", imem_addr, {p[31:2], 2'b00});
    quiet = (s && !r && !v) ? quiet + 1 : 0;
    if (quiet >= 3) check("addr_stable", imem_addr, prev_addr);
`ifdef IF_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt, m_fetch);
    check("bubble_cnt", bubble_cnt, m_bubble);
`endif
    prev_addr = imem_addr;
    p_rst = r; p_stall = s; p_rv = v; p_rpc = p; p_valid = e_valid;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;

    // Reset then free-run; single-cycle stall at pc 0x8; long stall at 0x10.
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (5) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'h0);

    // Redirect under stall with the hold buffer full.
    repeat (2) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 32'h43);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'h0);

    // Wrap-around at the top of the address space.
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);

    // Reset in the middle of a stall with the hold buffer full.
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 32'h80);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 32'h0);

    for (int n = 0; n < 2000; n++) begin
      logic        r, s, v;
      logic [31:0] p;
      r = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 40);
      v = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 7) == 0) p = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      else                           p = $urandom_range(0, 1023);
      cycle(r, s, v, p);
    end
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
